// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  // Width of an architectural register number.
  localparam int REG_W    = 5;
  // Width of the multiply/divide countdown (covers MD_LATENCY up to 63).
  localparam int MD_CNT_W = 6;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    EXC     = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: the ID instruction reads a register that the load
// currently in EXE will not have written back in time.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             exe_is_load,
  input  logic [REG_W-1:0] exe_wreg,
  output logic             load_use
);

  // Register 0 is hardwired to zero, so a load targeting it never conflicts.
  always_comb begin
    load_use = exe_is_load && (exe_wreg != '0) &&
               ((id_use_rs && (id_rs == exe_wreg)) ||
                (id_use_rt && (id_rt == exe_wreg)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stalls and flushes for load-use hazards,
// taken branches, exceptions and (optionally) multi-cycle mult/div.
// Optional feature: define PIPE_MULDIV_STALL_EN to build the MD_BUSY state
// and its countdown; without it exe_md_start is ignored and md_busy is 0.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             exe_is_load,
  input  logic [REG_W-1:0] exe_wreg,
  input  logic             exe_bj_taken,
  input  logic             exe_md_start,
  input  logic             exc_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_exe_en,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             exe_mem_flush,
  output logic             md_busy,
  output logic             exc_ack,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;

  hazard_detect u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .exe_is_load (exe_is_load),
    .exe_wreg    (exe_wreg),
    .load_use    (load_use)
  );

`ifdef PIPE_MULDIV_STALL_EN
  // The start cycle is the first stall cycle, so MD_BUSY lasts MD_LATENCY-2.
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 2);

  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

  // Mult/div countdown register.
  always_ff @(posedge clk) begin
    if (rst) md_cnt_q <= '0;
    else     md_cnt_q <= md_cnt_d;
  end
`else
  logic unused_md_start;
  assign unused_md_start = exe_md_start;
  localparam bit unused_md_latency = (MD_LATENCY > 0);
`endif

  // State and stall-counter registers; rst wins over any state.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic, priority exc_req > branch > mult/div.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_d = state_q;
`ifdef PIPE_MULDIV_STALL_EN
    md_cnt_d = md_cnt_q;
`endif
    case (state_q)
      RUN: begin
        if (exc_req) begin
          state_d = EXC;
        end
`ifdef PIPE_MULDIV_STALL_EN
        else if (!exe_bj_taken && exe_md_start) begin
          state_d  = (MD_LATENCY > 2) ? MD_BUSY : RUN;
          md_cnt_d = MD_LOAD;
        end
`endif
      end
`ifdef PIPE_MULDIV_STALL_EN
      // A branch cannot resolve while the mult/div occupies EXE, so only an
      // exception interrupts the countdown.
      MD_BUSY: begin
        if (exc_req) begin
          state_d  = EXC;
          md_cnt_d = '0;
        end else if (md_cnt_q <= MD_CNT_W'(1)) begin
          state_d  = RUN;
          md_cnt_d = '0;
        end else begin
          md_cnt_d = md_cnt_q - MD_CNT_W'(1);
        end
      end
`endif
      EXC:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Output decode from current state and this cycle's hazards.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_exe_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_flush = 1'b0;
    md_busy       = 1'b0;
    exc_ack       = 1'b0;
    if (rst) begin
      if_id_flush   = 1'b1;
      id_exe_flush  = 1'b1;
      exe_mem_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (exc_req) begin
            if_id_flush   = 1'b1;
            id_exe_flush  = 1'b1;
            exe_mem_flush = 1'b1;
          end else if (exe_bj_taken) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
          end
`ifdef PIPE_MULDIV_STALL_EN
          else if (exe_md_start) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_en     = 1'b0;
            exe_mem_flush = 1'b1;
            md_busy       = 1'b1;
          end
`endif
          else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_exe_flush = 1'b1;
          end
        end
`ifdef PIPE_MULDIV_STALL_EN
        MD_BUSY: begin
          md_busy = 1'b1;
          if (exc_req) begin
            if_id_flush   = 1'b1;
            id_exe_flush  = 1'b1;
            exe_mem_flush = 1'b1;
          end else begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_en     = 1'b0;
            exe_mem_flush = 1'b1;
          end
        end
`endif
        EXC: begin
          exc_ack     = 1'b1;
          if_id_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Saturating count of cycles where the front end is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table vectors, directed corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int MD_LAT = 32;
`ifdef PIPE_MULDIV_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, exe_wreg;
  logic       id_use_rs, id_use_rt, exe_is_load, exe_bj_taken, exe_md_start, exc_req;

  logic        pc_en, if_id_en, id_exe_en, if_id_flush, id_exe_flush, exe_mem_flush, md_busy, exc_ack;
  logic [15:0] stall_cnt;
  logic        s_pc_en, s_if_id_en, s_id_exe_en, s_if_id_flush, s_id_exe_flush, s_exe_mem_flush, s_md_busy, s_exc_ack;
  logic [3:0]  s_stall_cnt;

  pipe_hazard_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .exe_is_load(exe_is_load), .exe_wreg(exe_wreg), .exe_bj_taken(exe_bj_taken),
    .exe_md_start(exe_md_start), .exc_req(exc_req), .pc_en(pc_en), .if_id_en(if_id_en),
    .id_exe_en(id_exe_en), .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
    .exe_mem_flush(exe_mem_flush), .md_busy(md_busy), .exc_ack(exc_ack), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance for saturation checks.
  pipe_hazard_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .exe_is_load(exe_is_load), .exe_wreg(exe_wreg), .exe_bj_taken(exe_bj_taken),
    .exe_md_start(exe_md_start), .exc_req(exc_req), .pc_en(s_pc_en), .if_id_en(s_if_id_en),
    .id_exe_en(s_id_exe_en), .if_id_flush(s_if_id_flush), .id_exe_flush(s_id_exe_flush),
    .exe_mem_flush(s_exe_mem_flush), .md_busy(s_md_busy), .exc_ack(s_exc_ack), .stall_cnt(s_stall_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: an exception-ack flag, remaining stall cycles of a
  // mult/div, and two saturating stall counters.
  bit  m_exc_pending;
  int  m_md_left;
  int  m_cnt, m_cnt_s;
  bit  cnt_valid = 1'b0;
  logic [7:0] act_vec, exp_vec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output vector order: {pc_en, if_id_en, id_exe_en, if_id_flush, id_exe_flush, exe_mem_flush, md_busy, exc_ack}
  function automatic logic [7:0] model_expect();
    bit lu;
    lu = exe_is_load && (exe_wreg != 0) &&
         ((id_use_rs && id_rs == exe_wreg) || (id_use_rt && id_rt == exe_wreg));
    if (rst)                   return 8'b11111100;
    if (m_exc_pending)         return 8'b11110001;
    if (exc_req)               return {6'b111111, (m_md_left > 0), 1'b0};
    if (m_md_left > 0)         return 8'b00000110;
    if (exe_bj_taken)          return 8'b11111000;
    if (exe_md_start && MD_EN) return 8'b00000110;
    if (lu)                    return 8'b00101000;
    return 8'b11100000;
  endfunction

  task automatic model_update(input logic [7:0] e);
    if (rst) begin
      m_exc_pending = 1'b0;
      m_md_left     = 0;
      m_cnt         = 0;
      m_cnt_s       = 0;
    end else begin
      if (!e[7]) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 15) m_cnt_s++;
      end
      if (m_exc_pending) m_exc_pending = 1'b0;
      else if (exc_req) begin
        m_exc_pending = 1'b1;
        m_md_left     = 0;
      end else if (m_md_left > 0) m_md_left--;
      else if (exe_bj_taken) ;
      else if (exe_md_start && MD_EN) m_md_left = MD_LAT - 2;
    end
  endtask

  // One clock: compare at the falling edge, advance the model after the rising edge.
  task automatic cycle(input string name);
    @(negedge clk);
    exp_vec = model_expect();
    act_vec = {pc_en, if_id_en, id_exe_en, if_id_flush, id_exe_flush, exe_mem_flush, md_busy, exc_ack};
    check({name, " outputs"}, 32'(act_vec), 32'(exp_vec));
    if (cnt_valid) begin
      check({name, " stall_cnt"}, 32'(stall_cnt), m_cnt);
      check({name, " stall_cnt_w4"}, 32'(s_stall_cnt), m_cnt_s);
    end
    @(posedge clk);
    model_update(exp_vec);
    cnt_valid = 1'b1;
    #1;
  endtask

  task automatic set_idle();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    exe_is_load = 1'b0; exe_wreg = '0; exe_bj_taken = 1'b0; exe_md_start = 1'b0; exc_req = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rs, input logic [4:0] wreg);
    set_idle();
    exe_is_load = 1'b1; exe_wreg = wreg; id_rs = rs; id_use_rs = 1'b1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    cycle("rst");
    rst = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, is_load;
    logic [4:0] wreg;
    logic       bj;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int n_st;

    tbl[0] = '{"lu_rs",        5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 8'b00101000};
    tbl[1] = '{"lu_r0",        5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 8'b11100000};
    tbl[2] = '{"lu_rt",        5'd0,  5'd7,  1'b0, 1'b1, 1'b1, 5'd7,  1'b0, 8'b00101000};
    tbl[3] = '{"rt_unused",    5'd0,  5'd7,  1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 8'b11100000};
    tbl[4] = '{"not_load",     5'd5,  5'd5,  1'b1, 1'b1, 1'b0, 5'd5,  1'b0, 8'b11100000};
    tbl[5] = '{"no_match",     5'd8,  5'd10, 1'b1, 1'b1, 1'b1, 5'd9,  1'b0, 8'b11100000};
    tbl[6] = '{"bj_over_lu",   5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b1, 8'b11111000};
    tbl[7] = '{"bj_alone",     5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 8'b11111000};
    tbl[8] = '{"lu_r31",       5'd31, 5'd0,  1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 8'b00101000};

    // Reset state.
    set_idle();
    rst = 1'b1;
    cycle("reset");
    cycle("reset_hold");
    check("reset_outputs", 32'(act_vec), 32'h0000_00fc);
    rst = 1'b0;
    cycle("post_reset");
    check("reset_stall_cnt", 32'(stall_cnt), 0);

    // Single-cycle vectors from RUN.
    foreach (tbl[i]) begin
      set_idle();
      id_rs = tbl[i].rs; id_rt = tbl[i].rt; id_use_rs = tbl[i].use_rs; id_use_rt = tbl[i].use_rt;
      exe_is_load = tbl[i].is_load; exe_wreg = tbl[i].wreg; exe_bj_taken = tbl[i].bj;
      cycle(tbl[i].name);
      check({tbl[i].name, " table"}, 32'(act_vec), 32'(tbl[i].exp));
    end

    // One load-use bubble.
    do_reset();
    set_lu(5'd5, 5'd5);
    cycle("ldu");
    check("ldu_pc_en", 32'(act_vec[7]), 0);
    check("ldu_id_exe_flush", 32'(act_vec[3]), 1);
    set_idle();
    cycle("ldu_after");
    check("ldu_one_bubble", 32'(act_vec[7]), 1);
    check("ldu_stall_cnt", 32'(stall_cnt), 1);

    // Full mult/div stall.
    do_reset();
    exe_md_start = 1'b1;
    cycle("md_start");
    n_st = act_vec[7] ? 0 : 1;
    set_idle();
    for (int i = 0; i < 40; i++) begin
      cycle("md_run");
      if (!act_vec[7]) n_st++;
    end
    check("md_stall_cycles", n_st, MD_EN ? MD_LAT - 1 : 0);
    check("md_busy_done", 32'(act_vec[1]), 0);
    check("md_stall_cnt", 32'(stall_cnt), MD_EN ? MD_LAT - 1 : 0);

    // Exception on the 10th MD_BUSY cycle.
    do_reset();
    exe_md_start = 1'b1;
    cycle("mdx_start");
    set_idle();
    repeat (9) cycle("mdx_busy");
    exc_req = 1'b1;
    cycle("mdx_abort");
    check("abort_flushes", 32'(act_vec[4:2]), 7);
    check("abort_pc_en", 32'(act_vec[7]), 1);
    exc_req = 1'b0;
    cycle("mdx_ack");
    check("abort_ack", 32'(act_vec[0]), 1);
    cycle("mdx_run");
    check("abort_back_to_run", 32'(act_vec), 32'h0000_00e0);
    check("abort_stall_cnt", 32'(stall_cnt), MD_EN ? 10 : 0);

    // Branch and load-use together: branch wins, no stall counted.
    do_reset();
    set_lu(5'd5, 5'd5);
    exe_bj_taken = 1'b1;
    cycle("bj_lu");
    check("bj_lu_outputs", 32'(act_vec), 32'h0000_00f8);
    set_idle();
    cycle("bj_lu_after");
    check("bj_lu_stall_cnt", 32'(stall_cnt), 0);

    // Counter saturation on the 4-bit instance.
    do_reset();
    set_lu(5'd3, 5'd3);
    repeat (20) cycle("sat");
    set_idle();
    cycle("sat_after");
    check("sat_cnt_w4", 32'(s_stall_cnt), 15);
    check("sat_cnt_w16", 32'(stall_cnt), 20);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom % 64) == 0;
      exc_req      = ($urandom % 16) == 0;
      exe_bj_taken = ($urandom % 8) == 0;
      exe_md_start = ($urandom % 24) == 0;
      exe_is_load  = $urandom % 2;
      exe_wreg     = 5'($urandom % 4);
      id_rs        = 5'($urandom % 4);
      id_rt        = 5'($urandom % 4);
      id_use_rs    = $urandom % 2;
      id_use_rt    = $urandom % 2;
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
